// File: rtl/lock_pkg.sv
// Shared types and constants for the combination lock checker.
package lock_pkg;

    localparam int                DIAL_W    = 5;
    localparam logic [DIAL_W-1:0] DIAL_MAX  = 5'd30;
    localparam int                NUM_CODES = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S1,
        ST_S2,
        ST_OPEN,
        ST_LOCKOUT
    } lock_state_t;

    // Index k holds the k-th number of the combination
    typedef logic [NUM_CODES-1:0][DIAL_W-1:0] code_arr_t;

endpackage

// File: rtl/lock_edge_det.sv
// Rising-edge detector for the confirm button.
// arm_q stays low after reset until the button has been seen released, so a
// button held through reset release does not count as a press.
module lock_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic lvl_i,
    output logic rise_o
);

    logic enter_q;
    logic arm_q;

    // Track previous button level and arm once a released level is sampled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enter_q <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            enter_q <= lvl_i;
            if (!lvl_i) arm_q <= 1'b1;
        end
    end

    assign rise_o = lvl_i & ~enter_q & arm_q;

endmodule

// File: rtl/lock_code_checker.sv
// Three-number combination checker with failed-attempt lockout and timed open.
// Optional build macro CODE_PROG_EN: codes become writable while OPEN via
// prog_we/prog_idx, using the current dial value.
module lock_code_checker
    import lock_pkg::*;
#(
    parameter logic [DIAL_W-1:0] CODE0          = 5'd12,
    parameter logic [DIAL_W-1:0] CODE1          = 5'd25,
    parameter logic [DIAL_W-1:0] CODE2          = 5'd3,
    parameter int                MAX_TRIES      = 3,
    parameter int                LOCKOUT_CYCLES = 1000,
    parameter int                OPEN_CYCLES    = 5000,
    localparam int               FW             = $clog2(MAX_TRIES + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DIAL_W-1:0] dial,
    input  logic              enter,
    input  logic              relock,
`ifdef CODE_PROG_EN
    input  logic              prog_we,
    input  logic [1:0]        prog_idx,
`endif
    output logic              unlocked,
    output logic              locked_out,
    output logic [1:0]        stage,
    output logic [FW-1:0]     fail_cnt,
    output logic              dial_clr
);

    localparam int TMAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    lock_state_t       state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [FW-1:0]     fail_d;
    logic              clr_d;
    logic              entry;
    logic [DIAL_W-1:0] exp_code;
    logic              hit;
    code_arr_t         code_q;

    lock_edge_det u_edge (
        .clk_i  (CLK),
        .rst_i  (RST),
        .lvl_i  (enter),
        .rise_o (entry)
    );

`ifdef CODE_PROG_EN
    // Programmable combination; new values apply from the next attempt
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            code_q <= {CODE2, CODE1, CODE0};
        end else if (state_q == ST_OPEN && prog_we && prog_idx < 2'd3 && dial <= DIAL_MAX) begin
            code_q[prog_idx] <= dial;
        end
    end
`else
    assign code_q = {CODE2, CODE1, CODE0};
`endif

    // Select the number expected at the current stage and compare
    always_comb begin
        case (state_q)
            ST_S1:   exp_code = code_q[1];
            ST_S2:   exp_code = code_q[2];
            default: exp_code = code_q[0];
        endcase
        hit = (dial <= DIAL_MAX) && (dial == exp_code);
    end

    // Next-state, timer, failure count and dial-clear request
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_cnt;
        clr_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_S1, ST_S2: begin
                if (entry) begin
                    if (hit) begin
                        if (state_q == ST_S2) begin
                            state_d = ST_OPEN;
                            fail_d  = '0;
                            timer_d = TW'(OPEN_CYCLES - 1);
                        end else begin
                            state_d = (state_q == ST_IDLE) ? ST_S1 : ST_S2;
                        end
                    end else begin
                        clr_d = 1'b1;
                        if (int'(fail_cnt) + 1 >= MAX_TRIES) begin
                            fail_d  = FW'(MAX_TRIES);
                            state_d = ST_LOCKOUT;
                            timer_d = TW'(LOCKOUT_CYCLES - 1);
                        end else begin
                            fail_d  = fail_cnt + 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_OPEN: begin
                // relock and expiry share one exit, so only one pulse results
                if (relock || timer_q == '0) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    clr_d   = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                    clr_d   = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state plus outputs registered from the next state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            fail_cnt   <= '0;
            dial_clr   <= 1'b0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
            stage      <= 2'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            fail_cnt   <= fail_d;
            dial_clr   <= clr_d;
            unlocked   <= (state_d == ST_OPEN);
            locked_out <= (state_d == ST_LOCKOUT);
            stage      <= (state_d == ST_S1) ? 2'd1 : (state_d == ST_S2) ? 2'd2 : 2'd0;
        end
    end

endmodule
